align_norm_shifter: RTL and testbench

Parametrised multi-cycle mantissa shifter for the floating-point adder datapath, replacing the fixed 24-bit PIPO shift register. Mode 0 right-aligns a mantissa by a requested exponent difference with guard/round/sticky capture. Mode 1 left-normalises a mantissa to a leading one, bounded by a shift limit, and reports the count. It shifts up to STEP positions per cycle under a start/busy/done handshake, and sits between exponent compare and the significand adder, and after the adder for normalisation.

---
 rtl/align_norm_shifter.sv | 190 +++++++++++++++++++
 tb/tb_align_norm_shifter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/align_norm_shifter.sv
// align_norm_shifter: multi-cycle mantissa shifter: right-align with guard/round/sticky, or left-normalise to a leading one.
// Latency: load on the accepting edge, up to STEP positions per edge, done pulses after edge n+1 (n = shifting edges).
// Backpressure: start is taken only while busy=0; a start while busy is dropped (no queueing), results hold until the next accept.
//
// Ports:
//   Clk             clock, rising edge
//   Clear           asynchronous active-high reset, abandons any operation in flight
//   start/mode      request and operation select (0 = align right, 1 = normalise left)
//   I/shamt         mantissa and shift amount (align: exact amount, normalise: maximum)
//   A/guard/round   shifted mantissa and the two bits below it
//   sticky          OR of every bit shifted out below the round position
//   count           positions actually shifted
//   busy/done/zero  operation in progress, one-cycle completion pulse, result-is-zero flag
//
// Build option: define ALIGN_NORM_SHIFTER_NORM_EN to compile in normalise (mode 1).
// Without it, mode is ignored, every operation is an align, and no leading-zero logic exists.

module align_norm_shifter #(
  parameter int W    = 24,
  parameter int SW   = 8,
  parameter int STEP = 1
) (
  input  logic          Clk,
  input  logic          Clear,
  input  logic          start,
  input  logic          mode,
  input  logic [W-1:0]  I,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  A,
  output logic          guard,
  output logic          round,
  output logic          sticky,
  output logic [SW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          zero
);

  // Extended register: mantissa plus guard and round positions.
  localparam int EW = W + 2;
  // Bits examined per edge; clipped so tiny mantissas with a wide STEP never index past the register.
  localparam int NB = (STEP < EW) ? STEP : EW;
  localparam logic [SW-1:0] STEP_SW = SW'(STEP);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] ext_q, ext_d;
  logic          sticky_q, sticky_d;
  logic [SW-1:0] count_q, count_d;
  logic [SW-1:0] rem_q, rem_d;
  logic          zero_q, zero_d;
  logic          done_q, done_d;

  logic [SW-1:0] k;
  logic          lost;

`ifdef ALIGN_NORM_SHIFTER_NORM_EN
  logic          mode_q, mode_d;
  logic [SW-1:0] lz;
`else
  logic          mode_unused;
  assign mode_unused = mode;
`endif

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    rem_d    = rem_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    k        = '0;
    lost     = 1'b0;
`ifdef ALIGN_NORM_SHIFTER_NORM_EN
    mode_d   = mode_q;
    lz       = '0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          ext_d    = {I, 2'b00};
          sticky_d = 1'b0;
          count_d  = '0;
          // In normalise, rem counts down the remaining shift budget (shamt - count).
          rem_d    = shamt;
          zero_d   = 1'b0;
          state_d  = SHIFT;
`ifdef ALIGN_NORM_SHIFTER_NORM_EN
          mode_d   = mode;
`endif
        end
      end

      SHIFT: begin
`ifdef ALIGN_NORM_SHIFTER_NORM_EN
        if (mode_q) begin
          if (ext_q[EW-1] || (rem_q == '0) || (ext_q == '0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            zero_d  = (ext_q == '0);
          end else begin
            // Leading zeros within the top NB bits only; all-zero window reads as NB.
            lz = SW'(NB);
            for (int i = NB - 1; i >= 0; i--) begin
              if (ext_q[EW-1-i]) begin
                lz = SW'(i);
              end
            end
            k = STEP_SW;
            if (rem_q < k) begin
              k = rem_q;
            end
            if (lz < k) begin
              k = lz;
            end
            ext_d   = ext_q << k;
            rem_d   = rem_q - k;
            count_d = count_q + k;
          end
        end else
`endif
        begin
          if ((rem_q == '0) || (ext_q == '0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            zero_d  = (ext_q == '0);
          end else begin
            k = (rem_q < STEP_SW) ? rem_q : STEP_SW;
            // Bits leaving through ext[0] this edge feed the sticky.
            for (int i = 0; i < NB; i++) begin
              if (i < int'(k)) begin
                lost = lost | ext_q[i];
              end
            end
            ext_d    = ext_q >> k;
            sticky_d = sticky_q | lost;
            rem_d    = rem_q - k;
            count_d  = count_q + k;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q  <= IDLE;
      ext_q    <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
      rem_q    <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALIGN_NORM_SHIFTER_NORM_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ext_q    <= ext_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
`ifdef ALIGN_NORM_SHIFTER_NORM_EN
      mode_q   <= mode_d;
`endif
    end
  end

  assign A      = ext_q[EW-1:2];
  assign guard  = ext_q[1];
  assign round  = ext_q[0];
  assign sticky = sticky_q;
  assign count  = count_q;
  assign busy   = (state_q == SHIFT);
  assign done   = done_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_align_norm_shifter.sv
// Bench for align_norm_shifter: two instances (STEP=1 and STEP=4) share stimulus;
// results and done timing are compared with an arithmetic reference model.
module tb_align_norm_shifter;

  localparam int W  = 24;
  localparam int SW = 8;
`ifdef ALIGN_NORM_SHIFTER_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0]  a;
    logic          grd;
    logic          rnd;
    logic          stk;
    logic [SW-1:0] cnt;
    logic          zr;
  } res_t;

  logic          clk;
  logic          clear;
  logic          start;
  logic          mode;
  logic [W-1:0]  i_in;
  logic [SW-1:0] shamt;

  logic [W-1:0]  a1, a4;
  logic          g1, g4, r1, r4, s1, s4, b1, b4, d1, d4, z1, z4;
  logic [SW-1:0] c1, c4;
  res_t          cur1, cur4;

  assign cur1 = {a1, g1, r1, s1, c1, z1};
  assign cur4 = {a4, g4, r4, s4, c4, z4};

  int   checks = 0;
  int   errors = 0;
  res_t got1, got4;
  int   de1, de4;

  align_norm_shifter #(.W(W), .SW(SW), .STEP(1)) dut1 (
    .Clk(clk), .Clear(clear), .start(start), .mode(mode), .I(i_in), .shamt(shamt),
    .A(a1), .guard(g1), .round(r1), .sticky(s1), .count(c1), .busy(b1), .done(d1), .zero(z1)
  );

  align_norm_shifter #(.W(W), .SW(SW), .STEP(4)) dut4 (
    .Clk(clk), .Clear(clear), .start(start), .mode(mode), .I(i_in), .shamt(shamt),
    .A(a4), .guard(g4), .round(r4), .sticky(s4), .count(c4), .busy(b4), .done(d4), .zero(z4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: total shift and number of shifting edges from closed-form rules.
  function automatic res_t model(input bit m, input logic [W-1:0] iv, input int sh,
                                 input int step, output int n);
    longint unsigned ext, res, mask;
    int c, z, lz;
    bit s;
    res_t r;
    ext = 64'(iv) << 2;
    s   = 1'b0;
    if (!m) begin
      // z = right shifts needed to empty the register
      z = 0;
      for (int b = 0; b < W + 2; b++) if (ext[b]) z = b + 1;
      n = (sh + step - 1) / step;
      if ((z + step - 1) / step < n) n = (z + step - 1) / step;
      c = n * step;
      if (c > sh) c = sh;
      res  = ext >> c;
      mask = (64'd1 << c) - 64'd1;
      s    = (ext & mask) != 0;
    end else begin
      lz = 0;
      if (iv != 0) while (!iv[W-1-lz]) lz++;
      c   = (sh < lz) ? sh : lz;
      n   = (c + step - 1) / step;
      res = (ext << c) & ((64'd1 << (W + 2)) - 64'd1);
    end
    r.a   = res[W+1:2];
    r.grd = res[1];
    r.rnd = res[0];
    r.stk = s;
    r.cnt = c[SW-1:0];
    r.zr  = (res == 0);
    return r;
  endfunction

  // Drive one request and capture each instance's outputs and done edge index.
  task automatic run_op(input bit m, input logic [W-1:0] iv, input logic [SW-1:0] sv);
    @(negedge clk);
    start = 1'b1; mode = m; i_in = iv; shamt = sv;
    @(negedge clk);
    start = 1'b0;
    de1 = -1; de4 = -1;
    for (int e = 1; e <= 600 && (de1 < 0 || de4 < 0); e++) begin
      @(negedge clk);
      if (d1 && de1 < 0) begin de1 = e; got1 = cur1; end
      if (d4 && de4 < 0) begin de4 = e; got4 = cur4; end
    end
  endtask

  task automatic test_reset();
    clear = 1'b0; start = 1'b0; mode = 1'b0; i_in = '0; shamt = '0;
    #1 clear = 1'b1;
    @(negedge clk);
    checks++;
    if ({cur1, b1, d1} !== '0) begin
      errors++; $display("FAIL reset_dut1 got=%h exp=0", {cur1, b1, d1});
    end
    checks++;
    if ({cur4, b4, d4} !== '0) begin
      errors++; $display("FAIL reset_dut4 got=%h exp=0", {cur4, b4, d4});
    end
    clear = 1'b0;
  endtask

  task automatic test_align_plan();
    res_t e1, e4;
    int n1, n4;
    logic [W-1:0]  iv [5] = '{24'h800001, 24'hFFFFFF, 24'h000000, 24'h5A5A5A, 24'h000001};
    logic [SW-1:0] sv [5] = '{8'd3, 8'd30, 8'd7, 8'd0, 8'd26};
    for (int t = 0; t < 5; t++) begin
      run_op(1'b0, iv[t], sv[t]);
      e1 = model(1'b0, iv[t], int'(sv[t]), 1, n1);
      e4 = model(1'b0, iv[t], int'(sv[t]), 4, n4);
      checks++;
      if (got1 !== e1 || de1 != n1 + 1) begin
        errors++; $display("FAIL align_plan%0d_s1 got=%h@%0d exp=%h@%0d", t, got1, de1, e1, n1 + 1);
      end
      checks++;
      if (got4 !== e4 || de4 != n4 + 1) begin
        errors++; $display("FAIL align_plan%0d_s4 got=%h@%0d exp=%h@%0d", t, got4, de4, e4, n4 + 1);
      end
      if (t == 0) begin
        checks++;
        if (got1 !== {24'h100000, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0} || de1 != 4) begin
          errors++; $display("FAIL align_800001_lit got=%h@%0d exp=%h@4", got1, de1,
                             {24'h100000, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0});
        end
      end
      if (t == 1) begin
        checks++;
        if (got4 !== {24'h000000, 1'b0, 1'b0, 1'b1, 8'd28, 1'b1} || de4 != 8) begin
          errors++; $display("FAIL align_early_exit_lit got=%h@%0d exp=%h@8", got4, de4,
                             {24'h000000, 1'b0, 1'b0, 1'b1, 8'd28, 1'b1});
        end
      end
    end
  endtask

`ifdef ALIGN_NORM_SHIFTER_NORM_EN
  task automatic test_normalise();
    res_t e1, e4;
    int n1, n4;
    logic [W-1:0]  iv [4] = '{24'h000C00, 24'h000001, 24'h000000, 24'h3FFFFF};
    logic [SW-1:0] sv [4] = '{8'd31, 8'd5, 8'd9, 8'd0};
    for (int t = 0; t < 4; t++) begin
      run_op(1'b1, iv[t], sv[t]);
      e1 = model(1'b1, iv[t], int'(sv[t]), 1, n1);
      e4 = model(1'b1, iv[t], int'(sv[t]), 4, n4);
      checks++;
      if (got1 !== e1 || de1 != n1 + 1) begin
        errors++; $display("FAIL norm_plan%0d_s1 got=%h@%0d exp=%h@%0d", t, got1, de1, e1, n1 + 1);
      end
      checks++;
      if (got4 !== e4 || de4 != n4 + 1) begin
        errors++; $display("FAIL norm_plan%0d_s4 got=%h@%0d exp=%h@%0d", t, got4, de4, e4, n4 + 1);
      end
      if (t == 0) begin
        checks++;
        if (got1 !== {24'hC00000, 1'b0, 1'b0, 1'b0, 8'd12, 1'b0} || de1 != 13 || de4 != 4) begin
          errors++; $display("FAIL norm_c00_lit got=%h@%0d/%0d exp=%h@13/4", got1, de1, de4,
                             {24'hC00000, 1'b0, 1'b0, 1'b0, 8'd12, 1'b0});
        end
      end
      if (t == 2) begin
        checks++;
        if (got1 !== {24'h000000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1} || de1 != 1) begin
          errors++; $display("FAIL norm_zero_lit got=%h@%0d exp=zero@1", got1, de1);
        end
      end
    end
  endtask
`else
  task automatic test_mode_ignored();
    res_t e1, e4;
    int n1, n4;
    run_op(1'b1, 24'h000C00, 8'd31);
    e1 = model(1'b0, 24'h000C00, 31, 1, n1);
    e4 = model(1'b0, 24'h000C00, 31, 4, n4);
    checks++;
    if (got1 !== e1 || de1 != n1 + 1) begin
      errors++; $display("FAIL mode_ignored_s1 got=%h@%0d exp=%h@%0d", got1, de1, e1, n1 + 1);
    end
    checks++;
    if (got4 !== e4 || de4 != n4 + 1) begin
      errors++; $display("FAIL mode_ignored_s4 got=%h@%0d exp=%h@%0d", got4, de4, e4, n4 + 1);
    end
    checks++;
    if (got1.cnt !== 8'd14 || got1.zr !== 1'b1) begin
      errors++; $display("FAIL mode_ignored_lit got cnt=%0d zero=%b exp cnt=14 zero=1", got1.cnt, got1.zr);
    end
  endtask
`endif

  task automatic test_busy_ignore();
    res_t e1, e4;
    int n1, n4, dh1, dh4;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; i_in = 24'h123456; shamt = 8'd10;
    @(negedge clk);
    checks++;
    if ({b1, b4, d1, d4} !== 4'b1100) begin
      errors++; $display("FAIL busy_after_load got=%b exp=1100", {b1, b4, d1, d4});
    end
    // second start held across edge 1 while both instances are busy
    i_in = 24'h00FFFF; shamt = 8'd3;
    @(negedge clk);
    start = 1'b0;
    de1 = -1; de4 = -1; dh1 = 0; dh4 = 0;
    for (int e = 2; e <= 20; e++) begin
      @(negedge clk);
      if (d1) begin dh1++; if (de1 < 0) begin de1 = e; got1 = cur1; end end
      if (d4) begin dh4++; if (de4 < 0) begin de4 = e; got4 = cur4; end end
    end
    e1 = model(1'b0, 24'h123456, 10, 1, n1);
    e4 = model(1'b0, 24'h123456, 10, 4, n4);
    checks++;
    if (got1 !== e1 || de1 != n1 + 1 || dh1 != 1) begin
      errors++; $display("FAIL busy_ignore_s1 got=%h@%0d x%0d exp=%h@%0d x1", got1, de1, dh1, e1, n1 + 1);
    end
    checks++;
    if (got4 !== e4 || de4 != n4 + 1 || dh4 != 1) begin
      errors++; $display("FAIL busy_ignore_s4 got=%h@%0d x%0d exp=%h@%0d x1", got4, de4, dh4, e4, n4 + 1);
    end
  endtask

  task automatic test_clear_mid();
    res_t e1, e4;
    int n1, n4, dn;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; i_in = 24'hFFFFFF; shamt = 8'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    #1;
    checks++;
    if ({cur1, b1, d1, cur4, b4, d4} !== '0) begin
      errors++; $display("FAIL clear_mid got=%h/%h exp=0", {cur1, b1, d1}, {cur4, b4, d4});
    end
    @(negedge clk);
    clear = 1'b0;
    dn = 0;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if (d1 || d4 || b1 || b4) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL clear_no_done got=%0d active cycles exp=0", dn);
    end
    run_op(1'b0, 24'hC0FFEE, 8'd5);
    e1 = model(1'b0, 24'hC0FFEE, 5, 1, n1);
    e4 = model(1'b0, 24'hC0FFEE, 5, 4, n4);
    checks++;
    if (got1 !== e1 || de1 != n1 + 1 || got4 !== e4 || de4 != n4 + 1) begin
      errors++; $display("FAIL after_clear got=%h@%0d/%h@%0d exp=%h@%0d/%h@%0d",
                         got1, de1, got4, de4, e1, n1 + 1, e4, n4 + 1);
    end
  endtask

  task automatic test_back_to_back();
    res_t e1, e4;
    int n1, n4;
    int f1 [2];
    int f4 [2];
    int k1, k4;
    res_t r1b, r4b;
    e1 = model(1'b0, 24'hABCDEF, 9, 1, n1);
    e4 = model(1'b0, 24'hABCDEF, 9, 4, n4);
    k1 = 0; k4 = 0; f1 = '{-1, -1}; f4 = '{-1, -1};
    r1b = '0; r4b = '0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; i_in = 24'hABCDEF; shamt = 8'd9;
    @(negedge clk);
    for (int e = 1; e <= 40 && k1 < 2; e++) begin
      @(negedge clk);
      if (d1 && k1 < 2) begin f1[k1] = e; k1++; r1b = cur1; end
      if (d4 && k4 < 2) begin f4[k4] = e; k4++; r4b = cur4; end
    end
    start = 1'b0;
    checks++;
    if (f1[0] != n1 + 1 || f1[1] != 2 * n1 + 3 || r1b !== e1) begin
      errors++; $display("FAIL b2b_s1 got=%0d,%0d %h exp=%0d,%0d %h", f1[0], f1[1], r1b, n1 + 1, 2 * n1 + 3, e1);
    end
    checks++;
    if (f4[0] != n4 + 1 || f4[1] != 2 * n4 + 3 || r4b !== e4) begin
      errors++; $display("FAIL b2b_s4 got=%0d,%0d %h exp=%0d,%0d %h", f4[0], f4[1], r4b, n4 + 1, 2 * n4 + 3, e4);
    end
    for (int e = 0; e < 100 && (b1 || b4); e++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (b1 || b4) begin
      errors++; $display("FAIL b2b_drain got busy=%b%b exp=00", b1, b4);
    end
  endtask

  task automatic test_random();
    res_t e1, e4;
    int n1, n4;
    bit m;
    logic [W-1:0]  iv;
    logic [SW-1:0] sv;
    for (int t = 0; t < 40; t++) begin
      m  = 1'($urandom_range(0, 1));
      iv = W'($urandom) >> $urandom_range(0, 23);
      if ($urandom_range(0, 9) == 0) iv = '0;
      sv = SW'($urandom_range(0, 40));
      run_op(m, iv, sv);
      e1 = model(m && NORM, iv, int'(sv), 1, n1);
      e4 = model(m && NORM, iv, int'(sv), 4, n4);
      checks++;
      if (got1 !== e1 || de1 != n1 + 1) begin
        errors++; $display("FAIL rand%0d_s1 m=%b I=%h sh=%0d got=%h@%0d exp=%h@%0d",
                           t, m, iv, sv, got1, de1, e1, n1 + 1);
      end
      checks++;
      if (got4 !== e4 || de4 != n4 + 1) begin
        errors++; $display("FAIL rand%0d_s4 m=%b I=%h sh=%0d got=%h@%0d exp=%h@%0d",
                           t, m, iv, sv, got4, de4, e4, n4 + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_align_plan();
`ifdef ALIGN_NORM_SHIFTER_NORM_EN
    test_normalise();
`else
    test_mode_ignored();
`endif
    test_busy_ignore();
    test_clear_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
